// File: rtl/banco_registradores_multiporta_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Imported by the top and by the pending-write scoreboard.
package banco_registradores_multiporta_pkg;

  localparam int unsigned REG_ZERO_IDX = 0;

  // When set, port B overrides port A on a same-address write and on bypass.
  localparam bit PORTA_B_PRIORITARIA = 1'b1;

  function automatic int unsigned calc_addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/placar_pendencias.sv
// Per-register pending-write scoreboard with a registered popcount.
// Reservations take priority over releases of the same register.
module placar_pendencias
  import banco_registradores_multiporta_pkg::*;
#(
  parameter int unsigned tam_memoria = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned CNT_W       = 6,
  parameter bit          REG_ZERO    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_reserva,
  input  logic [ADDR_W-1:0]      i_end_reserva,
  input  logic                   i_lib_a,
  input  logic [ADDR_W-1:0]      i_end_lib_a,
  input  logic                   i_lib_b,
  input  logic [ADDR_W-1:0]      i_end_lib_b,
  output logic [tam_memoria-1:0] o_pendente,
  output logic [CNT_W-1:0]       o_num_pendentes
);

  logic [tam_memoria-1:0] r_pend;
  logic [tam_memoria-1:0] w_prox;
  logic [CNT_W-1:0]       r_num;
  logic [CNT_W-1:0]       w_cnt;

  always_comb begin
    w_prox = r_pend;
    if (i_lib_a) w_prox[i_end_lib_a] = 1'b0;
    if (i_lib_b) w_prox[i_end_lib_b] = 1'b0;
    // A new producer issued this cycle keeps the register busy.
    if (i_reserva) w_prox[i_end_reserva] = 1'b1;
    if (REG_ZERO) w_prox[REG_ZERO_IDX] = 1'b0;
    w_cnt = '0;
    for (int i = 0; i < int'(tam_memoria); i++) begin
      w_cnt = w_cnt + CNT_W'(w_prox[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_num  <= '0;
    end else begin
      r_pend <= w_prox;
      r_num  <= w_cnt;
    end
  end

  assign o_pendente      = r_pend;
  assign o_num_pendentes = r_num;

endmodule

// File: rtl/banco_registradores_multiporta.sv
// Register file with NUM_LEITURA combinational reads, two write ports,
// optional zero register, optional write-to-read bypass and a pending scoreboard.
module banco_registradores_multiporta
  import banco_registradores_multiporta_pkg::*;
#(
  parameter int unsigned tamanho_palavra = 32,
  parameter int unsigned tam_memoria     = 32,
  parameter int unsigned ADDR_W          = calc_addr_w(tam_memoria),
  parameter int unsigned NUM_LEITURA     = 3,
  parameter bit          REG_ZERO        = 1'b1,
  parameter bit          BYPASS          = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_LEITURA*ADDR_W-1:0]          end_leitura,
  output logic [NUM_LEITURA*tamanho_palavra-1:0] saida_dado,
  output logic [NUM_LEITURA-1:0]                 ocupado,
  input  logic                                   escrita_a,
  input  logic [ADDR_W-1:0]                      end_escrita_a,
  input  logic [tamanho_palavra-1:0]             dado_escrita_a,
  input  logic                                   escrita_b,
  input  logic [ADDR_W-1:0]                      end_escrita_b,
  input  logic [tamanho_palavra-1:0]             dado_escrita_b,
  input  logic                                   reserva,
  input  logic [ADDR_W-1:0]                      end_reserva,
  output logic [$clog2(tam_memoria+1)-1:0]       num_pendentes
);

  localparam int unsigned CNT_W = $clog2(tam_memoria + 1);

  logic [tamanho_palavra-1:0] r_mem [tam_memoria];
  logic [tam_memoria-1:0]     w_pendente;

  logic w_we_a, w_we_b, w_res_ok;
  assign w_we_a   = escrita_a && !(REG_ZERO && (end_escrita_a == ADDR_W'(REG_ZERO_IDX)));
  assign w_we_b   = escrita_b && !(REG_ZERO && (end_escrita_b == ADDR_W'(REG_ZERO_IDX)));
  assign w_res_ok = reserva && !(REG_ZERO && (end_reserva == ADDR_W'(REG_ZERO_IDX)));

  // hi = the port that wins on a same-address collision and on bypass.
  logic                       w_we_hi, w_we_lo;
  logic [ADDR_W-1:0]          w_addr_hi, w_addr_lo;
  logic [tamanho_palavra-1:0] w_data_hi, w_data_lo;
  assign w_we_hi   = PORTA_B_PRIORITARIA ? w_we_b : w_we_a;
  assign w_we_lo   = PORTA_B_PRIORITARIA ? w_we_a : w_we_b;
  assign w_addr_hi = PORTA_B_PRIORITARIA ? end_escrita_b : end_escrita_a;
  assign w_addr_lo = PORTA_B_PRIORITARIA ? end_escrita_a : end_escrita_b;
  assign w_data_hi = PORTA_B_PRIORITARIA ? dado_escrita_b : dado_escrita_a;
  assign w_data_lo = PORTA_B_PRIORITARIA ? dado_escrita_a : dado_escrita_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(tam_memoria); i++) r_mem[i] <= '0;
    end else begin
      if (w_we_lo) r_mem[w_addr_lo] <= w_data_lo;
      if (w_we_hi) r_mem[w_addr_hi] <= w_data_hi;
    end
  end

  placar_pendencias #(
    .tam_memoria (tam_memoria),
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .REG_ZERO    (REG_ZERO)
  ) u_placar (
    .clk             (clk),
    .rst             (rst),
    .i_reserva       (w_res_ok),
    .i_end_reserva   (end_reserva),
    .i_lib_a         (w_we_a),
    .i_end_lib_a     (end_escrita_a),
    .i_lib_b         (w_we_b),
    .i_end_lib_b     (end_escrita_b),
    .o_pendente      (w_pendente),
    .o_num_pendentes (num_pendentes)
  );

  for (genvar k = 0; k < int'(NUM_LEITURA); k++) begin : g_leitura
    logic [ADDR_W-1:0]          w_addr;
    logic [tamanho_palavra-1:0] w_dado;
    logic                       w_zero, w_hit_hi, w_hit_lo, w_res_hit;

    assign w_addr    = end_leitura[k*ADDR_W +: ADDR_W];
    assign w_zero    = REG_ZERO && (w_addr == ADDR_W'(REG_ZERO_IDX));
    assign w_hit_hi  = BYPASS && w_we_hi && (w_addr_hi == w_addr);
    assign w_hit_lo  = BYPASS && w_we_lo && (w_addr_lo == w_addr);
    assign w_res_hit = w_res_ok && (end_reserva == w_addr);

    always_comb begin
      w_dado = r_mem[w_addr];
      if (w_hit_hi)      w_dado = w_data_hi;
      else if (w_hit_lo) w_dado = w_data_lo;
      if (w_zero || rst) w_dado = '0;
    end

    assign saida_dado[k*tamanho_palavra +: tamanho_palavra] = w_dado;
    // A same-cycle write clears busy unless a new reservation lands on the register too.
    assign ocupado[k] = w_pendente[w_addr] && !rst && !((w_hit_hi || w_hit_lo) && !w_res_hit);
  end

endmodule

// File: tb/tb_banco_registradores_multiporta.sv
// Randomized and directed self-checking bench against an array-based reference model.
module tb_banco_registradores_multiporta;

  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int CW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  end_leitura;
  logic [NR*DW-1:0]  saida_dado;
  logic [NR-1:0]     ocupado;
  logic              escrita_a, escrita_b, reserva;
  logic [AW-1:0]     end_escrita_a, end_escrita_b, end_reserva;
  logic [DW-1:0]     dado_escrita_a, dado_escrita_b;
  logic [CW-1:0]     num_pendentes;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_mem [NREG];
  bit            m_pend [NREG];

  always #5 clk = ~clk;

  banco_registradores_multiporta #(
    .tamanho_palavra (DW),
    .tam_memoria     (NREG),
    .NUM_LEITURA     (NR),
    .REG_ZERO        (1'b1),
    .BYPASS          (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .end_leitura    (end_leitura),
    .saida_dado     (saida_dado),
    .ocupado        (ocupado),
    .escrita_a      (escrita_a),
    .end_escrita_a  (end_escrita_a),
    .dado_escrita_a (dado_escrita_a),
    .escrita_b      (escrita_b),
    .end_escrita_b  (end_escrita_b),
    .dado_escrita_b (dado_escrita_b),
    .reserva        (reserva),
    .end_reserva    (end_reserva),
    .num_pendentes  (num_pendentes)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (escrita_b && end_escrita_b == a) return dado_escrita_b;
    if (escrita_a && end_escrita_a == a) return dado_escrita_a;
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    bit wr;
    if (rst || a == 0) return 1'b0;
    wr = (escrita_a && end_escrita_a == a) || (escrita_b && end_escrita_b == a);
    if (wr && !(reserva && end_reserva == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic idle();
    escrita_a = 0; escrita_b = 0; reserva = 0;
    end_escrita_a = '0; end_escrita_b = '0; end_reserva = '0;
    dado_escrita_a = '0; dado_escrita_b = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    end_leitura[k*AW +: AW] = a;
  endtask

  // Inputs are set just after a negedge; check comb outputs, clock, then check the count.
  task automatic ciclo();
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rd%0d", k), saida_dado[k*DW +: DW], model_read(end_leitura[k*AW +: AW]));
      check($sformatf("ocp%0d", k), {31'b0, ocupado[k]}, {31'b0, model_busy(end_leitura[k*AW +: AW])});
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
    end else begin
      if (escrita_a && end_escrita_a != 0) begin
        m_mem[end_escrita_a] = dado_escrita_a; m_pend[end_escrita_a] = 0;
      end
      if (escrita_b && end_escrita_b != 0) begin
        m_mem[end_escrita_b] = dado_escrita_b; m_pend[end_escrita_b] = 0;
      end
      if (reserva && end_reserva != 0) m_pend[end_reserva] = 1;
    end
    #1;
    check("npend", {26'b0, num_pendentes}, DW'(model_count()));
    @(negedge clk);
    idle();
  endtask

  task automatic reset_pulse();
    rst = 1; idle(); ciclo(); rst = 0;
  endtask

  initial begin
    rst = 1; idle(); end_leitura = '0;
    for (int i = 0; i < NREG; i++) begin m_mem[i] = '0; m_pend[i] = 0; end
    @(negedge clk);
    #1;
    check("rst_rd0", saida_dado[DW-1:0], '0);
    check("rst_npend", {26'b0, num_pendentes}, '0);
    ciclo();
    rst = 0;

    // Dual-write collision: B wins
    escrita_a = 1; end_escrita_a = 7; dado_escrita_a = 32'h11;
    escrita_b = 1; end_escrita_b = 7; dado_escrita_b = 32'h22;
    ciclo();
    set_rd(0, 7); ciclo();
    check("coll_r7", saida_dado[DW-1:0], 32'h22);
    escrita_a = 1; end_escrita_a = 3; dado_escrita_a = 32'h33;
    escrita_b = 1; end_escrita_b = 4; dado_escrita_b = 32'h44;
    ciclo();
    set_rd(0, 3); set_rd(1, 4); ciclo();
    check("dual_r3", saida_dado[DW-1:0], 32'h33);
    check("dual_r4", saida_dado[2*DW-1:DW], 32'h44);

    // Zero register ignores writes and reservations
    escrita_a = 1; end_escrita_a = 0; dado_escrita_a = 32'hFFFF_FFFF;
    reserva = 1; end_reserva = 0; set_rd(2, 0);
    ciclo();
    ciclo();
    check("zero_rd", saida_dado[3*DW-1:2*DW], '0);
    check("zero_ocp", {31'b0, ocupado[2]}, '0);
    check("zero_npend", {26'b0, num_pendentes}, '0);

    // Bypass on port 1
    escrita_a = 1; end_escrita_a = 9; dado_escrita_a = 32'h1; ciclo();
    set_rd(1, 9); escrita_b = 1; end_escrita_b = 9; dado_escrita_b = 32'hABCD;
    #1 check("byp_r9", saida_dado[2*DW-1:DW], 32'hABCD);
    ciclo();

    // Scoreboard sequence
    reset_pulse();
    set_rd(0, 3); set_rd(1, 4);
    reserva = 1; end_reserva = 2; ciclo();
    check("sb_1", {26'b0, num_pendentes}, 1);
    reserva = 1; end_reserva = 3; ciclo();
    check("sb_2", {26'b0, num_pendentes}, 2);
    reserva = 1; end_reserva = 4; ciclo();
    check("sb_3", {26'b0, num_pendentes}, 3);
    escrita_a = 1; end_escrita_a = 3; dado_escrita_a = 32'h5;
    #1 check("sb_ocp_byp", {31'b0, ocupado[0]}, '0);
    ciclo();
    check("sb_rel", {26'b0, num_pendentes}, 2);
    check("sb_ocp3", {31'b0, ocupado[0]}, '0);
    reserva = 1; end_reserva = 4; escrita_b = 1; end_escrita_b = 4; dado_escrita_b = 32'h6;
    ciclo();
    check("sb_keep", {26'b0, num_pendentes}, 2);
    check("sb_ocp4", {31'b0, ocupado[1]}, 1);

    // Saturation
    for (int r = 1; r < NREG; r++) begin
      reserva = 1; end_reserva = AW'(r); ciclo();
    end
    check("sat_31", {26'b0, num_pendentes}, 31);
    reserva = 1; end_reserva = 5; ciclo();
    check("sat_hold", {26'b0, num_pendentes}, 31);

    // Randomized traffic with rare resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      escrita_a = $urandom_range(0, 1); end_escrita_a = AW'($urandom); dado_escrita_a = $urandom;
      escrita_b = $urandom_range(0, 1); end_escrita_b = AW'($urandom); dado_escrita_b = $urandom;
      reserva = ($urandom_range(0, 2) != 0); end_reserva = AW'($urandom);
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(0, 3))
          0: set_rd(k, end_escrita_a);
          1: set_rd(k, end_escrita_b);
          2: set_rd(k, end_reserva);
          default: set_rd(k, AW'($urandom));
        endcase
      end
      ciclo();
      rst = 0;
    end

    // Reset mid-run
    reserva = 1; end_reserva = 6; ciclo();
    escrita_a = 1; end_escrita_a = 5; dado_escrita_a = 32'hDEAD_BEEF; ciclo();
    set_rd(0, 5); #1 check("pre_rst_r5", saida_dado[DW-1:0], 32'hDEAD_BEEF);
    #2 rst = 1;
    #1 check("mid_rst_r5", saida_dado[DW-1:0], '0);
    check("mid_rst_npend", {26'b0, num_pendentes}, '0);
    @(negedge clk);
    ciclo();
    rst = 0;
    ciclo();
    check("post_rst_r5", saida_dado[DW-1:0], '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
